lsu_mem_access: RTL and testbench

- Load/store execution unit that consumes the decoder's memory controls: MemWr, MemtoReg and MemOp (RV32 funct3 encoding).
- Performs the access against a word-wide synchronous data RAM, with byte write enables and 1-cycle read latency.
- Handles sub-word and misaligned accesses. A misaligned access that crosses a word boundary is split into two RAM cycles.
- Sits between the core's execute stage and the data RAM, using a valid/ready request and a one-cycle response pulse.

---
 rtl/lsu_mem_access.sv | 162 ++++++++++++++++
 tb/tb_lsu_mem_access.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_access.sv
// Load/store unit for a word-wide synchronous data RAM with byte enables.
// Handles sub-word and misaligned accesses; word-crossing accesses take two RAM cycles.
module lsu_mem_access #(
  parameter int unsigned MEM_AW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_rd,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, A0, A1, FIN} state_t;

  state_t            state;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              wr_q;
  logic              err_q;
  logic              split_q;
  logic [MEM_AW-1:0] w1_q;
  logic [3:0]        mask_hi_q;
  logic [31:0]       wd_hi_q;
  logic [31:0]       lo_q;

  logic [1:0]        req_off;
  logic [2:0]        req_bytes;
  logic [3:0]        req_base;
  logic              req_split;
  logic              req_err;
  logic [7:0]        mask8;
  logic [63:0]       wd64;
  logic [MEM_AW-1:0] w0;
  logic [MEM_AW-1:0] w1;

  logic [31:0]       lo_v;
  logic [31:0]       hi_v;
  logic [63:0]       r64;
  logic [31:0]       load_ext;

  logic              unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:MEM_AW+2];

  always_comb begin
    req_off = req_addr[1:0];
    unique case (req_op[1:0])
      2'b00:   begin req_bytes = 3'd1; req_base = 4'h1; end
      2'b01:   begin req_bytes = 3'd2; req_base = 4'h3; end
      default: begin req_bytes = 3'd4; req_base = 4'hF; end
    endcase
    req_split = ({1'b0, req_off} + req_bytes) > 3'd4;
    req_err   = (req_op == 3'b011) || (req_op == 3'b110) || (req_op == 3'b111)
              || (req_wr == req_rd) || (req_wr && req_op[2]);
    mask8     = {4'h0, req_base} << req_off;
    wd64      = {32'h0, req_wdata} << {req_off, 3'b000};
    w0        = req_addr[MEM_AW+1:2];
    w1        = w0 + MEM_AW'(1);
  end

  // In FIN the RAM output holds the last word read: w0 for a single access, w1 for a split one.
  always_comb begin
    lo_v = split_q ? lo_q : mem_rdata;
    hi_v = split_q ? mem_rdata : '0;
    r64  = {hi_v, lo_v} >> {off_q, 3'b000};
    unique case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, r64[7:0]}  : {{24{r64[7]}},  r64[7:0]};
      2'b01:   load_ext = uns_q ? {16'h0, r64[15:0]} : {{16{r64[15]}}, r64[15:0]};
      default: load_ext = r64[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      split_q    <= 1'b0;
      w1_q       <= '0;
      mask_hi_q  <= '0;
      wd_hi_q    <= '0;
      lo_q       <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            off_q     <= req_off;
            size_q    <= req_op[1:0];
            uns_q     <= req_op[2];
            wr_q      <= req_wr;
            err_q     <= req_err;
            split_q   <= req_split;
            w1_q      <= w1;
            mask_hi_q <= mask8[7:4];
            wd_hi_q   <= wd64[63:32];
            if (req_err) begin
              state <= FIN;
            end else begin
              state     <= A0;
              mem_en    <= 1'b1;
              mem_addr  <= w0;
              mem_we    <= req_wr ? mask8[3:0] : 4'h0;
              mem_wdata <= req_wr ? wd64[31:0] : 32'h0;
            end
          end
        end
        A0: begin
          if (split_q) begin
            state     <= A1;
            mem_addr  <= w1_q;
            mem_we    <= wr_q ? mask_hi_q : 4'h0;
            mem_wdata <= wr_q ? wd_hi_q : 32'h0;
          end else begin
            state  <= FIN;
            mem_en <= 1'b0;
            mem_we <= '0;
          end
        end
        A1: begin
          state  <= FIN;
          lo_q   <= mem_rdata;
          mem_en <= 1'b0;
          mem_we <= '0;
        end
        FIN: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          resp_rdata <= (err_q || wr_q) ? 32'h0 : load_ext;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed self-checking bench for lsu_mem_access against a behavioural word RAM.
module tb_lsu_mem_access;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic          req_rd = 1'b0;
  logic [2:0]    req_op = 3'b000;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ram [0:(1<<AW)-1];
  logic [31:0] log_addr [4];
  logic [3:0]  log_we   [4];
  logic [31:0] log_wd   [4];
  int          log_n = 0;

  lsu_mem_access #(.MEM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_rd(req_rd), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    if (mem_en && log_n < 4) begin
      log_addr[log_n] = 32'(mem_addr);
      log_we[log_n]   = mem_we;
      log_wd[log_n]   = mem_wdata;
      log_n           = log_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issues one request and waits (bounded) for the response; lat counts negedges after accept.
  task automatic do_req(input logic wr, input logic rd, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    log_n     = 0;
    req_wr    = wr;
    req_rd    = rd;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat   = 0;
    rdata = 32'hBAD0BAD0;
    err   = 1'bx;
    for (int k = 1; k <= 12; k++) begin
      if (resp_valid) begin
        lat   = k;
        rdata = resp_rdata;
        err   = resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  int          stray;

  initial begin
    for (int i = 0; i < (1<<AW); i++) ram[i] = '0;

    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    do_req(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, lat, rd, er);
    check("sw_lat", 32'(lat), 32'd3);
    check("sw_ncyc", 32'(log_n), 32'd1);
    check("sw_addr", log_addr[0], 32'h40);
    check("sw_we", 32'(log_we[0]), 32'hF);
    check("sw_wdata", log_wd[0], 32'hDEADBEEF);
    check("sw_err", 32'(er), 32'd0);
    check("sw_rdata", rd, 32'h0);

    do_req(0, 1, 3'b010, 32'h100, 32'h0, lat, rd, er);
    check("lw_lat", 32'(lat), 32'd3);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", 32'(er), 32'd0);
    check("lw_we", 32'(log_we[0]), 32'h0);

    ram[32'h40] = 32'h800080F0;
    do_req(0, 1, 3'b000, 32'h100, 32'h0, lat, rd, er);
    check("lb", rd, 32'hFFFFFFF0);
    do_req(0, 1, 3'b100, 32'h100, 32'h0, lat, rd, er);
    check("lbu", rd, 32'h000000F0);
    do_req(0, 1, 3'b001, 32'h102, 32'h0, lat, rd, er);
    check("lh", rd, 32'hFFFF8000);
    do_req(0, 1, 3'b101, 32'h102, 32'h0, lat, rd, er);
    check("lhu", rd, 32'h00008000);
    check("lhu_lat", 32'(lat), 32'd3);

    do_req(1, 0, 3'b010, 32'h103, 32'h11223344, lat, rd, er);
    check("ssw_lat", 32'(lat), 32'd4);
    check("ssw_ncyc", 32'(log_n), 32'd2);
    check("ssw_a0_addr", log_addr[0], 32'h40);
    check("ssw_a0_we", 32'(log_we[0]), 32'h8);
    check("ssw_a0_wd", log_wd[0], 32'h44000000);
    check("ssw_a1_addr", log_addr[1], 32'h41);
    check("ssw_a1_we", 32'(log_we[1]), 32'h7);
    check("ssw_a1_wd", log_wd[1], 32'h00112233);
    check("ssw_ram40", ram[32'h40], 32'h440080F0);
    check("ssw_ram41", ram[32'h41], 32'h00112233);

    do_req(0, 1, 3'b010, 32'h103, 32'h0, lat, rd, er);
    check("slw_rdata", rd, 32'h11223344);
    check("slw_lat", 32'(lat), 32'd4);
    do_req(0, 1, 3'b001, 32'h103, 32'h0, lat, rd, er);
    check("slh_rdata", rd, 32'h00003344);

    ram[32'hFFFF] = 32'hAABBCCDD;
    ram[32'h0000] = 32'h55667788;
    do_req(0, 1, 3'b010, 32'h3FFFE, 32'h0, lat, rd, er);
    check("wrap_a0_addr", log_addr[0], 32'hFFFF);
    check("wrap_a1_addr", log_addr[1], 32'h0000);
    check("wrap_rdata", rd, 32'h7788AABB);
    check("wrap_lat", 32'(lat), 32'd4);

    do_req(0, 1, 3'b011, 32'h100, 32'h0, lat, rd, er);
    check("ill_op_err", 32'(er), 32'd1);
    check("ill_op_lat", 32'(lat), 32'd2);
    check("ill_op_rdata", rd, 32'h0);
    check("ill_op_mem", 32'(log_n), 32'd0);
    do_req(1, 1, 3'b010, 32'h100, 32'h12345678, lat, rd, er);
    check("ill_wrrd_err", 32'(er), 32'd1);
    check("ill_wrrd_lat", 32'(lat), 32'd2);
    check("ill_wrrd_mem", 32'(log_n), 32'd0);
    check("ill_wrrd_ram", ram[32'h40], 32'h440080F0);
    do_req(1, 0, 3'b100, 32'h100, 32'h0, lat, rd, er);
    check("ill_sbu_err", 32'(er), 32'd1);

    @(negedge clk);
    req_wr = 1'b0; req_rd = 1'b1; req_op = 3'b010; req_addr = 32'h103;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk) req_valid = 1'b0;
    @(negedge clk);
    check("rstmid_a1_addr", 32'(mem_addr), 32'h41);
    rst_n = 1'b0;
    #1;
    check("rstmid_mem_en", 32'(mem_en), 32'd0);
    check("rstmid_mem_we", 32'(mem_we), 32'd0);
    check("rstmid_mem_addr", 32'(mem_addr), 32'd0);
    check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    check("rstmid_ready", 32'(req_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid) stray++;
    end
    check("rstmid_no_resp", 32'(stray), 32'd0);
    do_req(0, 1, 3'b010, 32'h100, 32'h0, lat, rd, er);
    check("post_rst_lw", rd, 32'h440080F0);
    check("post_rst_lat", 32'(lat), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
